// File: rtl/mem_bus_access_if.sv
// Data-bus port bundle between the MEM-stage access unit (master) and the data memory (slave).
interface mem_bus_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_bus_access.sv
// MEM-stage load/store unit: one outstanding req/ack bus transaction, pipeline stall while pending,
// load-data extraction/extension, and misalignment flags that bypass the bus.
module mem_bus_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        hold_ext,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall_out,
  output logic [31:0] dm_out,
  output logic        exc_adel,
  output logic        exc_ades,
  mem_bus_access_if.master bus
);
  localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4, OP_LBU = 4'd5,
                         OP_SW = 4'd6, OP_SH = 4'd7, OP_SB  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;

  logic        is_load, is_store, aligned, live, access;
  logic [3:0]  byteen_d;
  logic [31:0] wdata_d;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] ldbuf;

  always_comb begin
    is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
    is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);
    case (mem_op)
      OP_LW, OP_SW:         aligned = (addr[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: aligned = ~addr[0];
      default:              aligned = 1'b1;
    endcase
    live     = valid_in & ~flush;
    access   = live & (is_load | is_store) & aligned;
    exc_adel = live & is_load  & ~aligned;
    exc_ades = live & is_store & ~aligned;
  end

  always_comb begin
    byteen_d = 4'b1111;
    wdata_d  = store_data;
    case (mem_op)
      OP_SH: begin
        byteen_d = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{store_data[15:0]}};
      end
      OP_SB: begin
        byteen_d = 4'b0001 << addr[1:0];
        wdata_d  = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        stall_out = access;
        if (access) state_d = BUSY;
      end
      BUSY: begin
        stall_out = 1'b1;
        if (bus.bus_ack) state_d = DONE;
      end
      DONE:    if (!hold_ext) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are latched once in IDLE and held untouched until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_byteen <= '0;
      bus.bus_wdata  <= '0;
      op_q           <= '0;
      off_q          <= '0;
      ldbuf          <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          bus.bus_req    <= 1'b1;
          bus.bus_we     <= is_store;
          bus.bus_addr   <= {addr[31:2], 2'b00};
          bus.bus_byteen <= byteen_d;
          bus.bus_wdata  <= wdata_d;
          op_q           <= mem_op;
          off_q          <= addr[1:0];
        end
        BUSY: if (bus.bus_ack) begin
          bus.bus_req <= 1'b0;
          bus.bus_we  <= 1'b0;
          ldbuf       <= bus.bus_rdata;
        end
        default: ;
      endcase
    end
  end

  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] byte_shift;

  always_comb begin
    half       = off_q[1] ? ldbuf[31:16] : ldbuf[15:0];
    byte_shift = ldbuf >> {off_q, 3'b000};
    byte_sel   = byte_shift[7:0];
    case (op_q)
      OP_LW:   dm_out = ldbuf;
      OP_LH:   dm_out = {{16{half[15]}}, half};
      OP_LHU:  dm_out = {16'h0000, half};
      OP_LB:   dm_out = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  dm_out = {24'h000000, byte_sel};
      default: dm_out = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_access.sv
// Randomized bench for mem_bus_access: a transaction-level model predicts every cycle's outputs,
// plus directed cases with hand-computed literal results.
module tb_mem_bus_access;
  logic        clk = 1'b0;
  logic        reset, valid_in, flush, hold_ext;
  logic [3:0]  mem_op;
  logic [31:0] addr, store_data;
  logic        stall_out, exc_adel, exc_ades;
  logic [31:0] dm_out;

  mem_bus_access_if bus();

  mem_bus_access dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush), .hold_ext(hold_ext),
    .mem_op(mem_op), .addr(addr), .store_data(store_data), .stall_out(stall_out),
    .dm_out(dm_out), .exc_adel(exc_adel), .exc_ades(exc_ades), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference rules ----
  function automatic logic is_ld(input logic [3:0] op);
    return op >= 1 && op <= 5;
  endfunction
  function automatic logic is_st(input logic [3:0] op);
    return op >= 6 && op <= 8;
  endfunction
  function automatic logic algn(input logic [3:0] op, input logic [31:0] a);
    if (op == 1 || op == 6) return a % 4 == 0;
    if (op == 2 || op == 3 || op == 7) return a % 2 == 0;
    return 1'b1;
  endfunction
  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    if (op == 7) return (a % 4 >= 2) ? 4'hC : 4'h3;
    if (op == 8) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction
  function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] sd);
    if (op == 7) return (sd & 32'hFFFF) * 32'h0001_0001;
    if (op == 8) return (sd & 32'hFF) * 32'h0101_0101;
    return sd;
  endfunction
  function automatic logic [31:0] exp_dm(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (op)
      1: return w;
      2: return (s & 32'h8000) ? (s | 32'hFFFF_0000) : (s & 32'hFFFF);
      3: return s & 32'hFFFF;
      4: return (s & 32'h80) ? (s | 32'hFFFF_FF00) : (s & 32'hFF);
      5: return s & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  // ---- per-cycle expectations, checked by the compare process ----
  logic        chk_en = 1'b0, chk_dm = 1'b0, chk_bus = 1'b0;
  logic        e_stall, e_req, e_we, e_exl, e_exs;
  logic [31:0] e_dm, e_addr, e_wd;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_out", 32'(stall_out), 32'(e_stall));
      chk("bus_req",   32'(bus.bus_req), 32'(e_req));
      chk("bus_we",    32'(bus.bus_we), 32'(e_we));
      chk("exc_adel",  32'(exc_adel), 32'(e_exl));
      chk("exc_ades",  32'(exc_ades), 32'(e_exs));
      if (chk_dm) chk("dm_out", dm_out, e_dm);
      if (chk_bus) begin
        chk("bus_addr",   bus.bus_addr, e_addr);
        chk("bus_byteen", 32'(bus.bus_byteen), 32'(e_be));
        chk("bus_wdata",  bus.bus_wdata, e_wd);
      end
    end
  end

  // ---- observations for directed literal checks ----
  int          obs_stalls, obs_req;
  logic        obs_we, obs_exl;
  logic [31:0] obs_dm, obs_addr, obs_wd;
  logic [3:0]  obs_be;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_rdata;
  logic [31:0] last_dm;

  task automatic cycle();
    @(negedge clk);
    obs_stalls += int'(stall_out);
    obs_exl    |= exc_adel;
    obs_dm      = dm_out;
    if (bus.bus_req) begin
      obs_req++;
      obs_we   = bus.bus_we;
      obs_addr = bus.bus_addr;
      obs_be   = bus.bus_byteen;
      obs_wd   = bus.bus_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic v, input logic fl, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] sd, input int wt, input int hold);
    logic        acc;
    logic [31:0] ack_data;
    acc = v && !fl && (is_ld(op) || is_st(op)) && algn(op, a);
    valid_in = v; flush = fl; mem_op = op; addr = a; store_data = sd;
    obs_stalls = 0; obs_req = 0; obs_exl = 1'b0;
    ack_data = 32'h0;
    if (!acc) begin
      hold_ext = 1'($urandom);
      bus.bus_ack = 1'($urandom); bus.bus_rdata = $urandom;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
      e_exl = v && !fl && is_ld(op) && !algn(op, a);
      e_exs = v && !fl && is_st(op) && !algn(op, a);
      chk_dm = 1'b1; e_dm = last_dm; chk_bus = 1'b0;
      cycle();
    end else begin
      e_addr = a & 32'hFFFF_FFFC; e_be = exp_be(op, a); e_wd = exp_wd(op, sd);
      e_exl = 1'b0; e_exs = 1'b0;
      for (int k = 0; k <= wt + 2 + hold; k++) begin
        flush    = (k == 0) ? 1'b0 : 1'($urandom);
        hold_ext = (k >= wt + 2) ? (k < wt + 2 + hold) : 1'($urandom);
        bus.bus_rdata = use_fixed ? fixed_rdata : $urandom;
        if (k >= 1 && k <= wt) bus.bus_ack = 1'b0;
        else if (k == wt + 1)  begin bus.bus_ack = 1'b1; ack_data = bus.bus_rdata; end
        else                   bus.bus_ack = 1'($urandom);
        e_stall = (k <= wt + 1);
        e_req   = (k >= 1 && k <= wt + 1);
        e_we    = e_req && is_st(op);
        chk_bus = e_req;
        chk_dm  = (k == 0) || (k >= wt + 2);
        e_dm    = (k == 0) ? last_dm : exp_dm(op, a, ack_data);
        cycle();
      end
      last_dm = exp_dm(op, a, ack_data);
    end
    flush = 1'b0; hold_ext = 1'b0; bus.bus_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; hold_ext = 1'b0; mem_op = 4'd0;
    addr = 32'h0; store_data = 32'h0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_dm = 32'h0;

    // reset state
    @(negedge clk);
    chk("rst bus_req", 32'(bus.bus_req), 32'h0);
    chk("rst dm_out", dm_out, 32'h0);
    chk("rst stall_out", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // SW, ack in first BUSY cycle
    run_instr(1, 0, 4'd6, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0);
    chk("sw req cycles", 32'(obs_req), 32'd1);
    chk("sw we", 32'(obs_we), 32'd1);
    chk("sw byteen", 32'(obs_be), 32'hF);
    chk("sw addr", obs_addr, 32'h0000_1004);
    chk("sw wdata", obs_wd, 32'hDEAD_BEEF);
    chk("sw stalls", 32'(obs_stalls), 32'd2);

    // LB with 3 wait cycles
    use_fixed = 1'b1; fixed_rdata = 32'h80FF_1234;
    run_instr(1, 0, 4'd4, 32'h0000_2003, 32'h0, 3, 0);
    chk("lb dm_out", obs_dm, 32'hFFFF_FF80);
    chk("lb stalls", 32'(obs_stalls), 32'd5);

    run_instr(1, 0, 4'd3, 32'h0000_2002, 32'h0, 1, 0);
    chk("lhu dm_out", obs_dm, 32'h0000_80FF);
    use_fixed = 1'b0;

    run_instr(1, 0, 4'd8, 32'h0000_3001, 32'h0000_00AB, 0, 0);
    chk("sb byteen", 32'(obs_be), 32'h2);
    chk("sb wdata", obs_wd, 32'hABAB_ABAB);

    run_instr(1, 0, 4'd1, 32'h0000_0006, 32'h0, 0, 0);
    chk("lw mis adel", 32'(obs_exl), 32'd1);
    chk("lw mis stalls", 32'(obs_stalls), 32'd0);
    chk("lw mis req", 32'(obs_req), 32'd0);

    // hold_ext keeps DONE for 2 extra cycles
    use_fixed = 1'b1; fixed_rdata = 32'h1234_5678;
    run_instr(1, 0, 4'd1, 32'h0000_0010, 32'h0, 0, 2);
    chk("hold dm_out", obs_dm, 32'h1234_5678);
    chk("hold req cycles", 32'(obs_req), 32'd1);
    chk("hold stalls", 32'(obs_stalls), 32'd2);
    use_fixed = 1'b0;

    // reset during second BUSY cycle of an LW
    chk_en = 1'b0;
    valid_in = 1'b1; mem_op = 4'd1; addr = 32'h0000_0040; bus.bus_ack = 1'b0;
    cycle();                 // IDLE
    cycle();                 // BUSY #1
    reset = 1'b1;
    cycle();                 // BUSY #2 with reset
    reset = 1'b0; valid_in = 1'b0; mem_op = 4'd0;
    @(negedge clk);
    chk("midrst bus_req", 32'(bus.bus_req), 32'h0);
    chk("midrst dm_out", dm_out, 32'h0);
    chk("midrst stall", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk("late ack req", 32'(bus.bus_req), 32'h0);
    chk("late ack dm_out", dm_out, 32'h0);
    @(posedge clk); #1;
    last_dm = 32'h0;
    chk_en = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      run_instr(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                4'($urandom_range(0, 15)), ra, $urandom,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
